// File: rtl/i2c_scl_gen_if.sv
// i2c_scl_gen_if: control inputs and SCL/SDA phase outputs of the SCL generator.
interface i2c_scl_gen_if;
  logic ena;
  logic scl_not_ena;
  logic scl_in;
  logic scl_clk;
  logic data_clk;
  logic data_clk_rise;
  logic switch_range;
  logic stretching;
  logic timeout;
  modport master (
    output ena, scl_not_ena, scl_in,
    input  scl_clk, data_clk, data_clk_rise, switch_range, stretching, timeout
  );
  modport slave (
    input  ena, scl_not_ena, scl_in,
    output scl_clk, data_clk, data_clk_rise, switch_range, stretching, timeout
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// i2c_scl_gen: four-quarter SCL/data phase generator with slave clock-stretch hold.
// Optional macro I2C_STRETCH_TIMEOUT_EN bounds a stretch to TO_CYCLES held cycles.
module i2c_scl_gen #(
  parameter int DIVIDER   = 3,
  parameter int CBITS     = 8,
  parameter int TO_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  i2c_scl_gen_if.slave io
);
  localparam logic [CBITS-1:0] L_Q1  = CBITS'(DIVIDER);
  localparam logic [CBITS-1:0] L_Q2  = CBITS'(2 * DIVIDER);
  localparam logic [CBITS-1:0] L_Q3  = CBITS'(3 * DIVIDER);
  localparam logic [CBITS-1:0] L_TOP = CBITS'(4 * DIVIDER - 1);
  logic [CBITS-1:0] r_cnt;
  logic [CBITS-1:0] w_next;
  logic r_scl_clk, r_data_clk, r_rise, r_switch, r_stretch;
  logic w_hold_raw, w_hold, w_scl, w_dclk, w_q2;
  assign w_hold_raw = io.ena && r_cnt == L_Q2 && !io.scl_not_ena && !io.scl_in;
`ifdef I2C_STRETCH_TIMEOUT_EN
  logic [15:0] r_scnt;
  logic r_timeout;
  logic w_to;
  assign w_to   = r_scnt >= 16'(TO_CYCLES);
  assign w_hold = w_hold_raw && !w_to;
  always_ff @(posedge clk) begin
    if (rst || !io.ena) begin
      r_scnt    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_scnt    <= w_hold ? r_scnt + 16'd1 : '0;
      r_timeout <= r_timeout || (w_hold_raw && w_to);
    end
  end
  assign io.timeout = r_timeout;
`else
  assign w_hold     = w_hold_raw;
  assign io.timeout = 1'b0;
`endif
  // Outputs decode the next count so they line up with r_cnt on the same edge.
  always_comb begin
    w_next = !io.ena ? '0 : w_hold ? r_cnt : (r_cnt == L_TOP) ? '0 : r_cnt + 1'b1;
    w_scl  = !io.ena || w_next >= L_Q2;
    w_dclk = io.ena && w_next >= L_Q1 && w_next < L_Q3;
    w_q2   = io.ena && w_next >= L_Q2 && w_next < L_Q3;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_scl_clk  <= 1'b1;
      r_data_clk <= 1'b0;
      r_rise     <= 1'b0;
      r_switch   <= 1'b0;
      r_stretch  <= 1'b0;
    end else begin
      r_cnt      <= w_next;
      r_scl_clk  <= w_scl;
      r_data_clk <= w_dclk;
      r_rise     <= w_dclk && !r_data_clk;
      r_switch   <= w_q2;
      r_stretch  <= w_hold;
    end
  end
  assign io.scl_clk       = r_scl_clk;
  assign io.data_clk      = r_data_clk;
  assign io.data_clk_rise = r_rise;
  assign io.switch_range  = r_switch;
  assign io.stretching    = r_stretch;
endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb_i2c_scl_gen: directed vectors with a queued scoreboard checked by a decoupled monitor.
module tb_i2c_scl_gen;
  typedef struct {
    bit idle;
    int cnt;
    bit str;
    bit to;
  } exp_t;
  logic clk, rst;
  i2c_scl_gen_if bus ();
  i2c_scl_gen #(.DIVIDER(3), .CBITS(8), .TO_CYCLES(10)) dut (.clk(clk), .rst(rst), .io(bus));
  exp_t q[$];
  int n_vec = 0;
  int n_miss = 0;
  int ec = 0;
  bit et = 0;
  bit prev_dclk = 0;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, n_vec, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      bit e_scl, e_dclk, e_sw;
      e = q.pop_front();
      n_vec++;
      e_scl  = e.idle || e.cnt >= 6;
      e_dclk = !e.idle && e.cnt >= 3 && e.cnt < 9;
      e_sw   = !e.idle && e.cnt >= 6 && e.cnt < 9;
      chk("cnt", int'(dut.r_cnt), e.idle ? 0 : e.cnt);
      chk("scl_clk", int'(bus.scl_clk), int'(e_scl));
      chk("data_clk", int'(bus.data_clk), int'(e_dclk));
      chk("data_clk_rise", int'(bus.data_clk_rise), int'(e_dclk && !prev_dclk));
      chk("switch_range", int'(bus.switch_range), int'(e_sw));
      chk("stretching", int'(bus.stretching), int'(e.str));
      chk("timeout", int'(bus.timeout), int'(e.to));
      prev_dclk = e_dclk;
    end
  end
  task automatic step(bit r, bit en, bit sne, bit sin, bit idle, int cnt, bit str, bit to);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.ena = en;
    bus.scl_not_ena = sne;
    bus.scl_in = sin;
    e.idle = idle;
    e.cnt = cnt;
    e.str = str;
    e.to = to;
    q.push_back(e);
  endtask
  task automatic adv(int n, bit sne, bit sin);
    repeat (n) begin
      ec = (ec == 11) ? 0 : ec + 1;
      step(0, 1, sne, sin, 0, ec, 0, et);
    end
  endtask
  task automatic hold(int n);
    repeat (n) step(0, 1, 0, 0, 0, ec, 1, et);
  endtask
  initial begin
    rst = 1;
    bus.ena = 0;
    bus.scl_not_ena = 0;
    bus.scl_in = 1;
    repeat (2) step(1, 1, 0, 0, 1, 0, 0, 0);
    adv(30, 0, 1);
    hold(5);
    adv(1, 0, 1);
    adv(11, 0, 0);
    adv(24, 1, 0);
`ifdef I2C_STRETCH_TIMEOUT_EN
    hold(10);
    et = 1;
    adv(1, 0, 0);
    adv(3, 0, 1);
`else
    hold(20);
    adv(1, 0, 1);
`endif
    adv((8 - ec + 12) % 12, 0, 1);
    ec = 0;
    et = 0;
    step(0, 0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    adv(3, 0, 1);
    adv(3, 0, 1);
    hold(2);
    step(1, 1, 0, 0, 1, 0, 0, 0);
    ec = 0;
    adv(14, 0, 1);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/i2c_scl_gen.md
I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

Interface
REQ-001 Parameter DIVIDER, default 3, clk cycles per SCL quarter-period; legal range >= 2.
REQ-002 Parameter CBITS, default 8, phase counter width; SHALL satisfy 2^CBITS > 4*DIVIDER-1, otherwise out of spec.
REQ-003 Parameter TO_CYCLES, default 255, maximum consecutive stretch-hold cycles; legal range 1..2^16-1.
REQ-004 clk  in  1  sole clock, all logic on posedge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 ena  in  1  run enable; 0 = idle.
REQ-007 scl_not_ena  in  1  1 = master not driving SCL, stretch detection disabled.
REQ-008 scl_in  in  1  synchronised SCL bus level.
REQ-009 scl_clk  out  1  registered SCL drive phase.
REQ-010 data_clk  out  1  registered SDA update/sample phase.
REQ-011 data_clk_rise  out  1  one-cycle pulse on data_clk 0->1.
REQ-012 switch_range  out  1  1 while in quarter Q2.
REQ-013 stretching  out  1  1 in cycles where the counter is held by a slave stretch.
REQ-014 timeout  out  1  sticky stretch-timeout flag.

Function
REQ-015 Counter cnt (CBITS) SHALL advance 0..4*DIVIDER-1 and wrap to 0, one step per clk when ena=1 and not held.
REQ-016 All outputs SHALL be registered and SHALL decode the cnt value written on the same edge, giving zero added latency versus cnt.
REQ-017 Quarter decode: Q0 cnt<DIVIDER gives scl_clk=0, data_clk=0; Q1 cnt<2*DIVIDER gives 0,1; Q2 cnt<3*DIVIDER gives 1,1; Q3 otherwise gives 1,0.
REQ-018 switch_range SHALL be 1 exactly when the decoded cnt is in Q2.
REQ-019 Hold condition: cnt==2*DIVIDER, scl_not_ena=0 and scl_in=0 -> cnt SHALL stay unchanged and stretching=1 for that edge.
REQ-020 The hold SHALL release on the first edge with scl_in=1 or scl_not_ena=1; cnt then advances to 2*DIVIDER+1.
REQ-021 Stretch is checked only at cnt==2*DIVIDER; scl_in=0 at any other count SHALL NOT hold cnt.
REQ-022 ena=0 SHALL force cnt=0, scl_clk=1, data_clk=0, switch_range=0, stretching=0 and clear timeout, all on the next edge.
REQ-023 On ena 0->1, the first edge SHALL load cnt=1 and Q0 outputs.
REQ-024 data_clk_rise SHALL be 1 for exactly one cycle whenever registered data_clk changes 0->1, and 0 otherwise.

Reset
REQ-025 rst=1 SHALL override ena and all other inputs, setting on the next edge: cnt=0, scl_clk=1, data_clk=0, data_clk_rise=0, switch_range=0, stretching=0, timeout=0, stretch counter=0.
REQ-026 Reset asserted mid-stretch SHALL abort the stretch, with no residual hold after rst deasserts.

Configuration
REQ-027 With macro I2C_STRETCH_TIMEOUT_EN defined, a 16-bit stretch counter SHALL count consecutive hold cycles and clear to 0 on any non-hold edge.
REQ-028 With I2C_STRETCH_TIMEOUT_EN defined, at most TO_CYCLES consecutive hold cycles are allowed; the edge that would be hold number TO_CYCLES+1 SHALL instead advance cnt, set stretching=0 and set timeout=1.
REQ-029 With I2C_STRETCH_TIMEOUT_EN defined, timeout SHALL remain 1 until rst or ena=0.
REQ-030 Without I2C_STRETCH_TIMEOUT_EN, no stretch counter SHALL exist, timeout SHALL be constant 0, and a hold SHALL last indefinitely.

Verification (DIVIDER=3)
REQ-031 Free run: rst then ena=1, scl_in=1 -> 12-cycle period; scl_clk low for cnt 0-5; data_clk high for cnt 3-8; data_clk_rise pulses once per period at cnt=3.
REQ-032 Stretch: scl_in=0 for 5 cycles at cnt=6 -> cnt stays 6 for 5 cycles, stretching=1 for 5 cycles, then cnt=7; period is 17 cycles.
REQ-033 scl_not_ena=1 with scl_in=0 throughout -> no hold, period stays 12, stretching never 1.
REQ-034 Timeout (macro defined, TO_CYCLES=10): scl_in stuck 0 -> exactly 10 hold cycles, then cnt=7 and timeout=1; timeout stays 1 until ena=0.
REQ-035 rst=1 during cycle 3 of a stretch -> next edge shows cnt=0, scl_clk=1, stretching=0; after release, normal sequence with no hold.
REQ-036 ena dropped at cnt=8 -> next edge cnt=0, scl_clk=1, data_clk=0; on re-enable the sequence restarts at cnt=1.
